// File: rtl/io_port_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_port_master: PicoBlaze-style I/O port bus initiator with single-cycle |
// | strobes. Optional macro IO_TX_POLL_EN polls STATUS_PORT before GATED_PORT |
// | writes.                                                                   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module io_port_master #(
  parameter int unsigned RD_LATENCY  = 1,
  parameter logic [7:0]  STATUS_PORT = 8'h03,
  parameter logic [7:0]  GATED_PORT  = 8'h01
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [7:0] req_port,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       stall,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] IO_port_ID,
  output logic [7:0] IO_write_data,
  output logic       IO_write_strobe,
  output logic       IO_read_strobe,
  input  logic [7:0] IO_read_data
);

  localparam int unsigned c_cnt_w = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [c_cnt_w-1:0] c_wait_init = c_cnt_w'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WSTB  = 3'd1,
    S_RSTB  = 3'd2,
    S_RWAIT = 3'd3,
    S_DONE  = 3'd4
`ifdef IO_TX_POLL_EN
    ,
    S_PSTB  = 3'd5,
    S_PWAIT = 3'd6,
    S_PGAP  = 3'd7
`endif
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;

`ifndef IO_TX_POLL_EN
  logic [7:0] w_unused_cfg;
  assign w_unused_cfg = STATUS_PORT ^ GATED_PORT;
`endif

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      req_ready       <= 1'b0;
      stall           <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_data        <= 8'h00;
      IO_port_ID      <= 8'h00;
      IO_write_data   <= 8'h00;
      IO_write_strobe <= 1'b0;
      IO_read_strobe  <= 1'b0;
    end else begin
      // Strobes and the completion pulse are single-cycle unless re-armed below.
      IO_write_strobe <= 1'b0;
      IO_read_strobe  <= 1'b0;
      rsp_valid       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_ready && req_valid) begin
            req_ready     <= 1'b0;
            stall         <= 1'b1;
            IO_port_ID    <= req_port;
            IO_write_data <= req_data;
            if (!req_write) begin
              IO_read_strobe <= 1'b1;
              r_state        <= S_RSTB;
            end
`ifdef IO_TX_POLL_EN
            else if (req_port == GATED_PORT) begin
              IO_port_ID     <= STATUS_PORT;
              IO_read_strobe <= 1'b1;
              r_state        <= S_PSTB;
            end
`endif
            else begin
              IO_write_strobe <= 1'b1;
              r_state         <= S_WSTB;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WSTB: begin
          rsp_valid <= 1'b1;
          rsp_data  <= 8'h00;
          stall     <= 1'b0;
          r_state   <= S_DONE;
        end
        S_RSTB: begin
          r_cnt   <= c_wait_init;
          r_state <= S_RWAIT;
        end
        S_RWAIT: begin
          if (r_cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= IO_read_data;
            stall     <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
`ifdef IO_TX_POLL_EN
        S_PSTB: begin
          r_cnt   <= c_wait_init;
          r_state <= S_PWAIT;
        end
        S_PWAIT: begin
          if (r_cnt == '0) begin
            if (IO_read_data[0]) begin
              r_state <= S_PGAP;
            end else begin
              IO_port_ID      <= GATED_PORT;
              IO_write_strobe <= 1'b1;
              r_state         <= S_WSTB;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PGAP: begin
          IO_read_strobe <= 1'b1;
          r_state        <= S_PSTB;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_port_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_io_port_master: directed bench with a schedule-based reference model. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_io_port_master;

  localparam int         L    = 1;
  localparam logic [7:0] STAT = 8'h03;
  localparam logic [7:0] GATE = 8'h01;
`ifdef IO_TX_POLL_EN
  localparam bit POLL  = 1'b1;
  localparam int EXTRA = 1;
`else
  localparam bit POLL  = 1'b0;
  localparam int EXTRA = 0;
`endif

  logic       clk100    = 1'b0;
  logic       reset     = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_port  = 8'h00;
  logic [7:0] req_data  = 8'h00;
  logic       req_ready, stall, rsp_valid, IO_write_strobe, IO_read_strobe;
  logic [7:0] rsp_data, IO_port_ID, IO_write_data;
  logic [7:0] IO_read_data = 8'h00;

  int vectors = 0;
  int errors  = 0;
  int p       = 0;

  io_port_master #(.RD_LATENCY(L), .STATUS_PORT(STAT), .GATED_PORT(GATE)) dut (
    .clk100(clk100), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_port(req_port), .req_data(req_data),
    .req_ready(req_ready), .stall(stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .IO_port_ID(IO_port_ID), .IO_write_data(IO_write_data),
    .IO_write_strobe(IO_write_strobe), .IO_read_strobe(IO_read_strobe),
    .IO_read_data(IO_read_data)
  );

  always #5 clk100 = ~clk100;

  // Peripheral contents: UART data, RX present, TX-full sequence 1,1,0 then 0.
  function automatic logic [7:0] port_value(input logic [7:0] port, input int sidx);
    case (port)
      8'h01:   return 8'h7E;
      8'h02:   return 8'h01;
      8'h03:   return (sidx < 2) ? 8'h01 : 8'h00;
      default: return port ^ 8'hA5;
    endcase
  endfunction

  int env_sidx = 0;
  always @(posedge clk100) begin
    if (IO_read_strobe) begin
      IO_read_data <= port_value(IO_port_ID, env_sidx);
      if (IO_port_ID == STAT) env_sidx <= env_sidx + 1;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at period %0d: got 0x%02h, want 0x%02h", name, p, act, exp);
    end
  endtask

  // Reference model: each accepted request is expanded into a timeline of periods.
  int         ready_from = 1 << 30;
  int         stall_from = 0;
  int         stall_to   = -1;
  bit         m_wstb    [int];
  bit         m_rstb    [int];
  logic [7:0] m_rsp     [int];
  logic [7:0] m_port_at [int];
  logic [7:0] m_port = 8'h00, m_wdata = 8'h00, m_rsp_data = 8'h00;
  int         m_sidx = 0;

  task automatic model_reset();
    m_wstb.delete(); m_rstb.delete(); m_rsp.delete(); m_port_at.delete();
    stall_to = -1; ready_from = 1 << 30;
    m_port = 8'h00; m_wdata = 8'h00; m_rsp_data = 8'h00;
  endtask

  task automatic model_accept(input int a, input logic w, input logic [7:0] port,
                              input logic [7:0] data);
    int done;
    int s;
    logic [7:0] v;
    m_wdata = data;
    done = a + 1;
    if (!w) begin
      m_rstb[a] = 1'b1;
      done = a + 1 + L;
      for (int k = a; k <= done; k++) m_port_at[k] = port;
      m_rsp[done] = port_value(port, m_sidx);
      if (port == STAT) m_sidx++;
    end else if (POLL && port == GATE) begin
      s = a;
      forever begin
        m_rstb[s] = 1'b1;
        for (int k = s; k <= s + L; k++) m_port_at[k] = STAT;
        v = port_value(STAT, m_sidx);
        m_sidx++;
        if (v[0]) begin
          m_port_at[s+L+1] = STAT;
          s = s + L + 2;
        end else begin
          m_wstb[s+L+1]    = 1'b1;
          m_port_at[s+L+1] = GATE;
          m_port_at[s+L+2] = GATE;
          done = s + L + 2;
          break;
        end
      end
      m_rsp[done] = 8'h00;
    end else begin
      m_wstb[a] = 1'b1;
      m_port_at[a] = port;
      m_port_at[a+1] = port;
      m_rsp[done] = 8'h00;
    end
    stall_from = a;
    stall_to   = done - 1;
    ready_from = done + 1;
  endtask

  initial begin
    forever begin
      @(posedge clk100);
      p++;
      if (!reset) begin
        model_reset();
        ready_from = p + 1;
      end else if (req_valid && (p - 1) >= ready_from) begin
        model_accept(p, req_write, req_port, req_data);
      end
      @(negedge clk100);
      if (!reset) model_reset();
      if (m_rsp.exists(p)) m_rsp_data = m_rsp[p];
      if (m_port_at.exists(p)) m_port = m_port_at[p];
      check("req_ready", {7'd0, req_ready}, {7'd0, reset && p >= ready_from});
      check("stall", {7'd0, stall}, {7'd0, reset && p >= stall_from && p <= stall_to});
      check("write_strobe", {7'd0, IO_write_strobe}, {7'd0, m_wstb.exists(p)});
      check("read_strobe", {7'd0, IO_read_strobe}, {7'd0, m_rstb.exists(p)});
      check("rsp_valid", {7'd0, rsp_valid}, {7'd0, m_rsp.exists(p)});
      check("rsp_data", rsp_data, m_rsp_data);
      check("port_id", IO_port_ID, m_port);
      check("write_data", IO_write_data, m_wdata);
    end
  end

  // Bus activity counters for the directed checks.
  int rd_cnt = 0, rd3_cnt = 0, wr_cnt = 0, rsp_cnt = 0;
  int last_rstb_p = 0, last_wstb_p = 0;
  logic [7:0] last_w_port = 8'h00, last_w_data = 8'h00;
  always @(negedge clk100) begin
    if (IO_read_strobe) begin
      rd_cnt++;
      last_rstb_p = p;
      if (IO_port_ID == STAT) rd3_cnt++;
    end
    if (IO_write_strobe) begin
      wr_cnt++;
      last_wstb_p = p;
      last_w_port = IO_port_ID;
      last_w_data = IO_write_data;
    end
    if (rsp_valid) rsp_cnt++;
  end

  task automatic issue(input logic w, input logic [7:0] port, input logic [7:0] data);
    bit ok;
    ok = 1'b0;
    @(posedge clk100); #2;
    req_valid = 1'b1; req_write = w; req_port = port; req_data = data;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk100);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk100); #2;
    if (!ok) begin
      vectors++; errors++;
      $display("FAIL accept_timeout port 0x%02h: got no req_ready, want req_ready within 64 cycles", port);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk100);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++; errors++;
      $display("FAIL idle_timeout: got req_ready=0, want 1 within 64 cycles");
    end
  endtask

  int r0, w0, v0;
  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    check("rst_ready", {7'd0, req_ready}, 8'h00);
    check("rst_stall", {7'd0, stall}, 8'h00);
    @(posedge clk100); #2 reset = 1'b1;
    @(negedge clk100);
    check("ready_before_edge", {7'd0, req_ready}, 8'h00);
    @(negedge clk100);
    check("ready_after_release", {7'd0, req_ready}, 8'h01);

`ifdef IO_TX_POLL_EN
    r0 = rd3_cnt; w0 = wr_cnt;
    issue(1'b1, 8'h01, 8'h5A);
    req_valid = 1'b0;
    wait_idle();
    check("poll_reads", 8'(rd3_cnt - r0), 8'd3);
    check("poll_writes", 8'(wr_cnt - w0), 8'd1);
    check("poll_w_port", last_w_port, 8'h01);
    check("poll_w_data", last_w_data, 8'h5A);
`endif

    issue(1'b1, 8'h01, 8'h41);
    req_valid = 1'b0;
`ifndef IO_TX_POLL_EN
    @(negedge clk100);
    check("out_wstb", {7'd0, IO_write_strobe}, 8'h01);
    check("out_rstb", {7'd0, IO_read_strobe}, 8'h00);
    check("out_port", IO_port_ID, 8'h01);
    check("out_data", IO_write_data, 8'h41);
    @(negedge clk100);
    check("out_rsp_valid", {7'd0, rsp_valid}, 8'h01);
    check("out_rsp_data", rsp_data, 8'h00);
`endif
    wait_idle();

    issue(1'b0, 8'h02, 8'h00);
    req_valid = 1'b0;
    @(negedge clk100);
    check("in_rstb", {7'd0, IO_read_strobe}, 8'h01);
    check("in_wstb", {7'd0, IO_write_strobe}, 8'h00);
    check("in_port", IO_port_ID, 8'h02);
    @(negedge clk100);
    check("in_rsp_early", {7'd0, rsp_valid}, 8'h00);
    check("in_rstb_once", {7'd0, IO_read_strobe}, 8'h00);
    @(negedge clk100);
    check("in_rsp_valid", {7'd0, rsp_valid}, 8'h01);
    check("in_rsp_data", rsp_data, 8'h01);
    wait_idle();

    r0 = rd_cnt; w0 = wr_cnt; v0 = rsp_cnt;
    issue(1'b0, 8'h01, 8'h00);
    issue(1'b1, 8'h01, 8'h55);
    req_valid = 1'b0;
    wait_idle();
    check("b2b_reads", 8'(rd_cnt - r0), 8'(1 + EXTRA));
    check("b2b_writes", 8'(wr_cnt - w0), 8'd1);
    check("b2b_rsps", 8'(rsp_cnt - v0), 8'd2);
    check("b2b_gap_ge2", {7'd0, (last_wstb_p - last_rstb_p) >= 2}, 8'h01);
    check("b2b_w_data", last_w_data, 8'h55);

    v0 = rsp_cnt;
    issue(1'b0, 8'h02, 8'h00);
    @(posedge clk100); #2 reset = 1'b0;
    #1;
    check("rst_mid_stall", {7'd0, stall}, 8'h00);
    check("rst_mid_rstb", {7'd0, IO_read_strobe}, 8'h00);
    check("rst_mid_wstb", {7'd0, IO_write_strobe}, 8'h00);
    req_valid = 1'b0;
    repeat (3) @(posedge clk100);
    #2 reset = 1'b1;
    @(negedge clk100);
    @(negedge clk100);
    check("rst_mid_ready", {7'd0, req_ready}, 8'h01);
    check("rst_mid_no_rsp", 8'(rsp_cnt - v0), 8'd0);

    issue(1'b0, 8'h01, 8'h00);
    req_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
